c3lib_rstseq: RTL and testbench
===============================

# c3lib_rstseq

Parametrised multi-channel reset synchroniser and ordered release sequencer. Each channel's asynchronous active-low reset request is synchronised into `clk`, and a minimum assertion time is enforced. Channel resets are then released in ascending index order with a fixed gap between channels, so channel i never leaves reset before channels 0..i-1. Used where several dependent sub-blocks in one clock domain (adapter, FIFO, datapath, CSR) need staged reset release, with the same scan bypass behaviour as the single-bit reset synchroniser.

## Interface
Parameters:
- `NUM_CH`, default 4: number of reset channels; must be ≥1.
- `SYNC_STAGES`, default 2: synchroniser flop depth per request bit; must be ≥2.
- `MIN_ASSERT_CYC`, default 8: consecutive request-free cycles required before the first release; must be ≥1.
- `GAP_CYC`, default 4: cycles between successive channel releases; must be ≥1.

Ports:
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: master reset; synchronous, active-low.
- `scan_mode_n` in 1: 0 selects scan bypass.
- `rst_n_bypass` in 1: reset value driven on all outputs in scan mode.
- `rst_req_n` in NUM_CH: per-channel reset request, asynchronous, active-low.
- `rst_n_out` in/out: out NUM_CH: per-channel reset, active-low, registered (muxed in scan).
- `seq_done` out 1: high when all channels are released.

## Operation
- **Synchronisers:** each `rst_req_n` bit passes through a chain of `SYNC_STAGES` flops.
  - Chain reset value is 0 (request asserted); D input is the raw request.
  - `sync_req_n` is the last stage. `req_any` = any `sync_req_n` bit is 0. `req_min` = lowest index with `sync_req_n` = 0.
- **State:** `state` ∈ {ASSERT, RELEASE, DONE}; `idx` in [0, NUM_CH-1]; `cnt` sized `$clog2(max(MIN_ASSERT_CYC, GAP_CYC)+1)`.
- **rst_n = 0 at an edge:**
  - `state`=ASSERT, `idx`=0, `cnt`=0, all sync flops 0.
  - `rst_n_out`=0 on all channels, `seq_done`=0.
  - Takes priority over everything else.
- **ASSERT:**
  - Outputs at index ≥ `idx` are held at 0.
  - If `req_any`: `cnt` goes to 0.
  - Otherwise `cnt` increments. When `cnt`==MIN_ASSERT_CYC-1 and `req_any` is 0: `rst_n_out[idx]`←1, `cnt`←0, and the state goes to RELEASE. If `idx`==NUM_CH-1, it goes to DONE instead.
- **RELEASE:** `cnt` increments. When `cnt`==GAP_CYC-1, the next channel is released:
  - `idx`←`idx`+1 and `rst_n_out[idx+1]`←1, `cnt`←0.
  - Go to DONE if `idx+1`==NUM_CH-1; otherwise stay in RELEASE.
- **DONE:** `seq_done`=1; all outputs stay 1.
- **Re-request (any state, `req_any`=1):**
  - Let k = min(`req_min`, `idx`) in ASSERT, otherwise k = `req_min`.
  - At the next edge, `rst_n_out[j]`←0 for every j ≥ k. Outputs below k are unchanged.
  - `idx`←k, `cnt`←0, `state`←ASSERT, `seq_done`←0.
  - When several requests are simultaneous, the lowest index wins.
  - A request arriving in the same cycle as a release overrides that release.
- **Scan bypass (`scan_mode_n`=0):**
  - `rst_n_out` = {NUM_CH{`rst_n_bypass`}} and `seq_done` = `rst_n_bypass`, both combinational.
  - Internal state keeps running untouched. Returning to `scan_mode_n`=1 immediately shows the registered values.

## Timing
- Edge 1 is the first rising edge with `rst_n`=1 and all `rst_req_n`=1.
  - `sync_req_n` reads all-1 after edge `SYNC_STAGES`.
  - `rst_n_out[0]` rises at edge SYNC_STAGES+MIN_ASSERT_CYC.
  - `rst_n_out[i]` rises GAP_CYC edges after `rst_n_out[i-1]`.
  - `seq_done` rises on the same edge as `rst_n_out[NUM_CH-1]`.
- Defaults: channels 0, 1, 2, 3 rise at edges 10, 14, 18, 22; `seq_done` rises at 22.
- Request assertion to output fall: SYNC_STAGES+1 edges (3 with defaults).
- Request deassertion to first re-release: SYNC_STAGES+MIN_ASSERT_CYC edges.
- NUM_CH=1: there is no RELEASE phase; ASSERT goes directly to DONE.
- A request pulse shorter than one `clk` period may be missed. The requester must hold it ≥ SYNC_STAGES+1 cycles.

## Test plan
- **Default release order:** defaults, deassert `rst_n` with all requests high → outputs rise at edges 10/14/18/22 in order 0→3; `seq_done` rises at 22; everything is 0 before edge 10.
- **Mid-sequence re-request:** pulse `rst_req_n[2]` low for 5 cycles after DONE → channels 2 and 3 fall 3 edges after assertion while 0 and 1 stay high; channel 2 re-rises 10 edges after deassertion, channel 3 rises 4 edges after that; `seq_done` returns to 1.
- **Simultaneous requests:** assert `rst_req_n[3]` and `rst_req_n[1]` together during RELEASE with `idx`=2 → channels 1..3 fall, channel 0 is held high, and the sequence restarts at index 1.
- **Hold restart:** during ASSERT, pulse any request low each time `cnt` reaches 5 → `rst_n_out[0]` never rises; after the last pulse it rises SYNC_STAGES+8 edges after deassertion.
- **Synchronous reset mid-operation:** drive `rst_n`=0 at edge 16 → all outputs and `seq_done` are 0 at edge 16; once `rst_n` returns high the full sequence replays from edge 1.
- **Scan bypass:** with `scan_mode_n`=0, toggle `rst_n_bypass` → all outputs and `seq_done` follow combinationally. Then set `scan_mode_n`=1 → outputs show the registered state with no disturbance to the sequence position.

Source files
------------

// File: rtl/c3lib_rstseq.sv
// Multi-channel reset synchroniser with ordered, gapped release.
// Channel i is never released before channels 0..i-1; scan mode bypasses all outputs.
module c3lib_rstseq #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned MIN_ASSERT_CYC = 8,
    parameter int unsigned GAP_CYC        = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scan_mode_n,
    input  logic              rst_n_bypass,
    input  logic [NUM_CH-1:0] rst_req_n,
    output logic [NUM_CH-1:0] rst_n_out,
    output logic              seq_done
);

    localparam int unsigned IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_MAX = (MIN_ASSERT_CYC > GAP_CYC) ? MIN_ASSERT_CYC : GAP_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
    logic [NUM_CH-1:0]                  sync_req_n;
    logic                               req_any;
    logic [IDX_W-1:0]                   req_min;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] rst_q, rst_d;
    logic              done_q, done_d;
    logic [IDX_W-1:0]  idx_inc;
    logic [IDX_W-1:0]  k;

    assign sync_req_n = sync_q[SYNC_STAGES-1];
    assign req_any    = ~&sync_req_n;

    // Lowest requesting channel wins
    always_comb begin
        req_min = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (!sync_req_n[i]) req_min = IDX_W'(i);
        end
    end

    // State register and request synchronisers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= ST_ASSERT;
            idx_q   <= '0;
            cnt_q   <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rst_req_n};
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
        end
    end

    // Next-state: hold, release, then let any re-request override the release
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rst_d   = rst_q;
        idx_inc = idx_q + IDX_W'(1);
        k       = req_min;

        case (state_q)
            ST_ASSERT: begin
                if (!req_any) begin
                    if (cnt_q == CNT_W'(MIN_ASSERT_CYC - 1)) begin
                        for (int j = 0; j < int'(NUM_CH); j++) begin
                            if (IDX_W'(j) == idx_q) rst_d[j] = 1'b1;
                        end
                        cnt_d   = '0;
                        state_d = (idx_q == IDX_W'(NUM_CH - 1)) ? ST_DONE : ST_RELEASE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RELEASE: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    for (int j = 0; j < int'(NUM_CH); j++) begin
                        if (IDX_W'(j) == idx_inc) rst_d[j] = 1'b1;
                    end
                    idx_d   = idx_inc;
                    cnt_d   = '0;
                    state_d = (idx_inc == IDX_W'(NUM_CH - 1)) ? ST_DONE : ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_ASSERT;
            end
        endcase

        if (req_any) begin
            if ((state_q == ST_ASSERT) && (idx_q < req_min)) k = idx_q;
            for (int j = 0; j < int'(NUM_CH); j++) begin
                if (IDX_W'(j) >= k) rst_d[j] = 1'b0;
            end
            idx_d   = k;
            cnt_d   = '0;
            state_d = ST_ASSERT;
        end

        done_d = (state_d == ST_DONE);
    end

    // Scan bypass overrides the registered outputs without touching state
    assign rst_n_out = scan_mode_n ? rst_q  : {NUM_CH{rst_n_bypass}};
    assign seq_done  = scan_mode_n ? done_q : rst_n_bypass;

endmodule

// File: tb/tb_c3lib_rstseq.sv
// Directed bench for c3lib_rstseq with default parameters.
// Expected values are edge-indexed from the first edge after master reset release.
module tb_c3lib_rstseq;

    localparam int unsigned NUM_CH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              scan_mode_n;
    logic              rst_n_bypass;
    logic [NUM_CH-1:0] rst_req_n;
    logic [NUM_CH-1:0] rst_n_out;
    logic              seq_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    c3lib_rstseq #(
        .NUM_CH        (4),
        .SYNC_STAGES   (2),
        .MIN_ASSERT_CYC(8),
        .GAP_CYC       (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scan_mode_n (scan_mode_n),
        .rst_n_bypass(rst_n_bypass),
        .rst_req_n   (rst_req_n),
        .rst_n_out   (rst_n_out),
        .seq_done    (seq_done)
    );

    // Compares {seq_done, rst_n_out} against the expected vector
    task automatic chk(input string tag, input int step, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {seq_done, rst_n_out};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s step=%0d observed=%b expected=%b", tag, step, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Default release schedule: channel i at edge 10+4i, done at edge 22
    function automatic logic [4:0] exp_def(input int e);
        logic [4:0] v;
        for (int i = 0; i < 4; i++) v[i] = (e >= 10 + 4 * i);
        v[4] = (e >= 22);
        return v;
    endfunction

    task automatic run_def(input string tag, input int from, input int to);
        for (int e = from; e <= to; e++) begin
            tick();
            chk(tag, e, exp_def(e));
        end
    endtask

    // Leaves the bench #1 after an edge so the next edge is edge 1
    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        chk("reset", 0, 5'b00000);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [4:0] ev;
        rst_n        = 1'b0;
        scan_mode_n  = 1'b1;
        rst_n_bypass = 1'b0;
        rst_req_n    = '1;

        // Default release order
        do_reset();
        run_def("default", 1, 25);

        // Channel 2 re-request after DONE
        rst_req_n[2] = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            ev[0] = 1'b1;
            ev[1] = 1'b1;
            ev[2] = !(n >= 3 && n < 15);
            ev[3] = !(n >= 3 && n < 19);
            ev[4] = !(n >= 3 && n < 19);
            chk("rereq", n, ev);
            if (n == 5) rst_req_n[2] = 1'b1;
        end

        // Simultaneous requests on 1 and 3 during RELEASE with idx=2
        do_reset();
        run_def("pre_simul", 1, 19);
        rst_req_n = 4'b0101;
        for (int n = 1; n <= 23; n++) begin
            tick();
            ev[0] = 1'b1;
            ev[1] = !(n >= 3 && n < 14);
            ev[2] = (n < 3) || (n >= 18);
            ev[3] = (n >= 22);
            ev[4] = (n >= 22);
            chk("simul", n, ev);
            if (n == 4) rst_req_n = '1;
        end

        // Hold restart: request pulses each time the counter reaches 5
        do_reset();
        for (int e = 1; e <= 30; e++) begin
            tick();
            ev = {4'b0000, (e >= 30)};
            chk("hold", e, ev);
            rst_req_n[0] = !((e >= 7 && e < 10) || (e >= 17 && e < 20));
        end

        // Synchronous reset mid-sequence, then full replay
        do_reset();
        run_def("pre_rst", 1, 15);
        rst_n = 1'b0;
        tick();
        chk("mid_rst", 16, 5'b00000);
        rst_n = 1'b1;
        run_def("replay", 1, 12);

        // Scan bypass inside one clock period, then resume
        scan_mode_n  = 1'b0;
        rst_n_bypass = 1'b1;
        #1 chk("scan_hi", 12, 5'b11111);
        rst_n_bypass = 1'b0;
        #1 chk("scan_lo", 12, 5'b00000);
        rst_n_bypass = 1'b1;
        #1 chk("scan_hi2", 12, 5'b11111);
        scan_mode_n = 1'b1;
        #1 chk("scan_exit", 12, exp_def(12));
        run_def("post_scan", 13, 22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
